// File: rtl/zorro_master_xfer.sv
// rtl/zorro_master_xfer.sv - NCR 53C710 DMA master cycles to Zorro III master data cycles.
// Optional DTACK timeout abort is built when ZORRO_TIMEOUT_EN is defined.
module zorro_master_xfer #(
`ifdef ZORRO_TIMEOUT_EN
  parameter int TIMEOUT_CYCLES = 64,
`endif
  parameter int RECOVER_CYCLES = 1
) (
  input  logic       bclk,
  input  logic       RESET_n,
  input  logic       mybus,
  input  logic       NCR_AS_n,
  input  logic       NCR_DS_n,
  input  logic       NCR_READ,
  input  logic [1:0] NCR_SIZ,
  input  logic [1:0] NCR_A,
  input  logic       DTACK,
  input  logic       BERR_n,
  output logic       FCS,
  output logic       DOE,
  output logic [3:0] DS_n,
  output logic       READ,
  output logic       NCR_SLACK_n,
  output logic       NCR_BERR_n
);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT, S_TERM, S_RECOV} state_t;

  state_t     state;
  logic [1:0] siz_l;
  logic [1:0] a_l;
  logic       armed;
  logic [7:0] rcnt;
`ifdef ZORRO_TIMEOUT_EN
  logic [7:0] tcnt;
`endif

  // Lanes run from 3-A downward for the transfer length, clipped at lane 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] siz, input logic [1:0] a);
    logic [2:0] len;
    logic [2:0] start;
    logic [3:0] m;
    len   = (siz == 2'b00) ? 3'd4 : {1'b0, siz};
    start = {1'b0, ~a};
    m     = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (3'(i) <= start && 3'(i) + len > start) m[i] = 1'b1;
    return m;
  endfunction

  always_ff @(negedge bclk or negedge RESET_n) begin
    if (!RESET_n) begin
      state       <= S_IDLE;
      FCS         <= 1'b0;
      DOE         <= 1'b0;
      DS_n        <= 4'hF;
      READ        <= 1'b1;
      NCR_SLACK_n <= 1'b1;
      NCR_BERR_n  <= 1'b1;
      siz_l       <= 2'b00;
      a_l         <= 2'b00;
      armed       <= 1'b1;
      rcnt        <= 8'd0;
`ifdef ZORRO_TIMEOUT_EN
      tcnt        <= 8'd0;
`endif
    end else begin
      // A new cycle needs AS to have been seen negated since the last one started.
      if (NCR_AS_n) armed <= 1'b1;
      if (state != S_IDLE &&
          (!mybus || (NCR_AS_n && (state == S_ADDR || state == S_DATA || state == S_WAIT)))) begin
        state       <= S_IDLE;
        FCS         <= 1'b0;
        DOE         <= 1'b0;
        DS_n        <= 4'hF;
        READ        <= 1'b1;
        NCR_SLACK_n <= 1'b1;
        NCR_BERR_n  <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (mybus && !NCR_AS_n && armed) begin
              state <= S_ADDR;
              FCS   <= 1'b1;
              READ  <= NCR_READ;
              siz_l <= NCR_SIZ;
              a_l   <= NCR_A;
              armed <= 1'b0;
`ifdef ZORRO_TIMEOUT_EN
              tcnt  <= 8'd0;
`endif
            end
          end
          S_ADDR: begin
            state <= S_DATA;
            DOE   <= 1'b1;
            if (READ) DS_n <= ~lane_mask(siz_l, a_l);
          end
          S_DATA: begin
            // Write byte strobes wait for the NCR to present data.
            if (READ) begin
              state <= S_WAIT;
            end else if (!NCR_DS_n) begin
              DS_n  <= ~lane_mask(siz_l, a_l);
              state <= S_WAIT;
            end
          end
          S_WAIT: begin
            if (!BERR_n) begin
              state      <= S_TERM;
              NCR_BERR_n <= 1'b0;
            end else if (DTACK) begin
              state       <= S_TERM;
              NCR_SLACK_n <= 1'b0;
            end
`ifdef ZORRO_TIMEOUT_EN
            else if (tcnt == 8'(TIMEOUT_CYCLES - 1)) begin
              state      <= S_TERM;
              NCR_BERR_n <= 1'b0;
              tcnt       <= 8'(TIMEOUT_CYCLES);
            end else begin
              tcnt <= tcnt + 8'd1;
            end
`endif
          end
          S_TERM: begin
            state       <= S_RECOV;
            FCS         <= 1'b0;
            DOE         <= 1'b0;
            DS_n        <= 4'hF;
            READ        <= 1'b1;
            NCR_SLACK_n <= 1'b1;
            NCR_BERR_n  <= 1'b1;
            rcnt        <= 8'd0;
          end
          S_RECOV: begin
            if (rcnt >= 8'(RECOVER_CYCLES - 1)) state <= S_IDLE;
            else rcnt <= rcnt + 8'd1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_zorro_master_xfer.sv
// tb/tb_zorro_master_xfer.sv - scoreboard bench for zorro_master_xfer.
// Build with ZORRO_TIMEOUT_EN defined to exercise the DTACK timeout.
module tb_zorro_master_xfer;

  localparam int RECOVER = 1;
  localparam int TMO     = 64;
  localparam logic [8:0] RST_V = 9'b0_0_1111_1_1_1;

  logic       bclk;
  logic       RESET_n;
  logic       mybus;
  logic       NCR_AS_n;
  logic       NCR_DS_n;
  logic       NCR_READ;
  logic [1:0] NCR_SIZ;
  logic [1:0] NCR_A;
  logic       DTACK;
  logic       BERR_n;
  logic       FCS;
  logic       DOE;
  logic [3:0] DS_n;
  logic       READ;
  logic       NCR_SLACK_n;
  logic       NCR_BERR_n;
  logic [8:0] outs;

  int total;
  int bad;

  typedef struct {
    logic [3:0] ds;
    logic       rd;
    logic [1:0] term;  // 0 none, 1 slack, 2 berr
  } exp_t;
  exp_t sb[$];

  zorro_master_xfer #(.RECOVER_CYCLES(RECOVER)) dut (
    .bclk(bclk), .RESET_n(RESET_n), .mybus(mybus), .NCR_AS_n(NCR_AS_n),
    .NCR_DS_n(NCR_DS_n), .NCR_READ(NCR_READ), .NCR_SIZ(NCR_SIZ), .NCR_A(NCR_A),
    .DTACK(DTACK), .BERR_n(BERR_n), .FCS(FCS), .DOE(DOE), .DS_n(DS_n), .READ(READ),
    .NCR_SLACK_n(NCR_SLACK_n), .NCR_BERR_n(NCR_BERR_n)
  );

  assign outs = {FCS, DOE, DS_n, READ, NCR_SLACK_n, NCR_BERR_n};

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte lanes from 3-A down to max(0, 3-A-len+1), active low.
  function automatic logic [3:0] model_ds(input logic [1:0] siz, input logic [1:0] a);
    int hi, lo, len;
    logic [3:0] m;
    len = (siz == 2'b00) ? 4 : int'(siz);
    hi  = 3 - int'(a);
    lo  = hi - len + 1;
    if (lo < 0) lo = 0;
    m = 4'b0000;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return ~m;
  endfunction

  task automatic cyc();
    @(posedge bclk);
  endtask

  // kind: 0 mybus abort (with DTACK), 1 DTACK, 2 BERR, 3 DTACK+BERR together
  task automatic xfer(input logic rd, input logic [1:0] siz, input logic [1:0] a,
                      input int ds_dly, input int ack_dly, input int kind,
                      input bit hold_as, input bit b2b);
    exp_t e;
    int n;
    e.ds   = model_ds(siz, a);
    e.rd   = rd;
    e.term = (kind == 0) ? 2'd0 : (kind == 1) ? 2'd1 : 2'd2;
    sb.push_back(e);
    if (!b2b) repeat (2) cyc();
    NCR_READ = rd; NCR_SIZ = siz; NCR_A = a; NCR_DS_n = 1'b1; NCR_AS_n = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (!FCS && n < 20);
    if (b2b) check("recov_gap", (n > RECOVER) ? 1 : 0, 1);
    else check("fcs_lat", n, 1);
    if (!rd) begin
      for (int d = 0; d < ds_dly; d++) begin
        cyc();
        check("ds_hold", DS_n, 4'hF);
        check("read_w", READ, 1'b0);
      end
      NCR_DS_n = 1'b0;
    end
    n = 0;
    do begin cyc(); n++; end while (DS_n == 4'hF && n < 20);
    check("ds_lat", n, 1);
    e = sb.pop_front();
    check("ds", DS_n, e.ds);
    check("read", READ, e.rd);
    check("doe", DOE, 1'b1);
    repeat (ack_dly) cyc();
    case (kind)
      0: begin mybus = 1'b0; DTACK = 1'b1; end
      1: DTACK = 1'b1;
      2: BERR_n = 1'b0;
      default: begin DTACK = 1'b1; BERR_n = 1'b0; end
    endcase
    cyc();
    check("slack", NCR_SLACK_n, (e.term == 2'd1) ? 1'b0 : 1'b1);
    check("berr", NCR_BERR_n, (e.term == 2'd2) ? 1'b0 : 1'b1);
    if (e.term == 2'd0) check("abort", outs, RST_V);
    else check("fcs_term", FCS, 1'b1);
    DTACK = 1'b0; BERR_n = 1'b1; mybus = 1'b1;
    if (!hold_as) begin NCR_AS_n = 1'b1; NCR_DS_n = 1'b1; end
    cyc();
    check("release", outs, RST_V);
  endtask

  task automatic timeout_test();
    int n;
    int terms;
    repeat (2) cyc();
    NCR_READ = 1'b1; NCR_SIZ = 2'b00; NCR_A = 2'b00; NCR_AS_n = 1'b0;
    n = 0;
    do begin cyc(); n++; end while (DS_n == 4'hF && n < 20);
    check("tmo_ds", DS_n, 4'h0);
`ifdef ZORRO_TIMEOUT_EN
    // DS_n shows one edge before WAIT entry, hence the extra clock.
    n = 0;
    while (NCR_BERR_n && n < 200) begin cyc(); n++; end
    check("tmo_berr_at", n, TMO + 1);
    check("tmo_slack", NCR_SLACK_n, 1'b1);
    cyc();
    check("tmo_berr_pulse", NCR_BERR_n, 1'b1);
`else
    terms = 0;
    for (int i = 0; i < 200; i++) begin
      cyc();
      if (!NCR_BERR_n || !NCR_SLACK_n) terms++;
    end
    check("no_tmo_term", terms, 0);
    check("no_tmo_fcs", FCS, 1'b1);
`endif
    NCR_AS_n = 1'b1;
    cyc(); cyc();
    check("tmo_release", outs, RST_V);
  endtask

  initial begin
    int cnt;
    total = 0; bad = 0;
    RESET_n = 1'b0; mybus = 1'b1; NCR_AS_n = 1'b1; NCR_DS_n = 1'b1; NCR_READ = 1'b1;
    NCR_SIZ = 2'b00; NCR_A = 2'b00; DTACK = 1'b0; BERR_n = 1'b1;
    repeat (2) cyc();
    check("reset", outs, RST_V);
    RESET_n = 1'b1;
    cyc();
    check("idle", outs, RST_V);

    xfer(1'b1, 2'b00, 2'd0, 0, 3, 1, 1'b0, 1'b0);  // long read A=0
    xfer(1'b0, 2'b01, 2'd2, 2, 1, 1, 1'b0, 1'b0);  // byte write A=2
    xfer(1'b1, 2'b10, 2'd3, 0, 2, 2, 1'b0, 1'b0);  // word read A=3, bus error
    xfer(1'b0, 2'b00, 2'd1, 1, 1, 3, 1'b0, 1'b0);  // long write A=1, BERR+DTACK
    for (int i = 0; i < 6; i++)
      xfer(1'($urandom_range(1)), 2'($urandom_range(3)), 2'($urandom_range(3)),
           1 + $urandom_range(2), 1 + $urandom_range(2), 1, 1'b0, 1'b0);
    xfer(1'b1, 2'b00, 2'd0, 0, 1, 0, 1'b0, 1'b0);  // mybus drop in WAIT

    // AS held through termination must not start another cycle
    xfer(1'b1, 2'b11, 2'd1, 0, 1, 1, 1'b1, 1'b0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin cyc(); if (FCS) cnt++; end
    check("no_retrig", cnt, 0);
    NCR_AS_n = 1'b1; NCR_DS_n = 1'b1;
    cyc();
    xfer(1'b1, 2'b11, 2'd1, 0, 1, 1, 1'b0, 1'b0);
    xfer(1'b0, 2'b10, 2'd0, 1, 1, 1, 1'b0, 1'b1);  // immediate re-request

    timeout_test();

    // asynchronous reset while stalled in DATA
    repeat (2) cyc();
    NCR_READ = 1'b0; NCR_SIZ = 2'b00; NCR_A = 2'd0; NCR_DS_n = 1'b1; NCR_AS_n = 1'b0;
    repeat (3) cyc();
    check("doe_data", DOE, 1'b1);
    #2 RESET_n = 1'b0;
    #1 check("async_rst", outs, RST_V);
    NCR_AS_n = 1'b1;
    cyc();
    RESET_n = 1'b1;
    cyc();
    check("post_rst", outs, RST_V);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
